display_arbiter: RTL and testbench
==================================

# display_arbiter

Round-robin arbiter and pacing controller that shares the single Avalon-ST display sink between up to `NUM_SRC` word producers. These producers are the pattern generator, the UART bridge, the switch sampler and the test ROM. It accepts one 32-bit word from the winning source, presents it to the display sink, then holds off further grants for a programmable dwell time so each value stays visible on the HEX/LED outputs. It sits between the producers and the display block on the same 50 MHz clock.

## Interface
- `NUM_SRC`, 4, number of requesters, 2..8
- `DATA_W`, 32, word width
- `HOLD_CYCLES`, 50_000_000, dwell cycles after each delivered word (1 s at 50 MHz); 0 disables dwell
- `clk`  input  1  system clock, 50 MHz
- `rst`  input  1  asynchronous active-low reset
- `src_data`  input  NUM_SRC*DATA_W  source words, source i at bits [i*DATA_W +: DATA_W]
- `src_valid`  input  NUM_SRC  per-source Avalon-ST valid
- `src_ready`  output  NUM_SRC  per-source Avalon-ST ready, ready latency 0
- `out_data`  output  DATA_W  word to display sink
- `out_src`  output  3  index of the source that produced `out_data`
- `out_valid`  output  1  Avalon-ST valid to display sink
- `out_ready`  input  1  Avalon-ST ready from display sink
- `busy`  output  1  high whenever state is not IDLE

## Operation
- FSM states: IDLE, SEND, HOLD. Reset state is IDLE.
- **IDLE**
  - Winner `w` is the first source with `src_valid` set, searching `last+1, last+2, …` modulo NUM_SRC.
  - `src_ready[w]=1` combinationally. All other `src_ready` bits are 0.
  - The transfer completes in that cycle.
  - On the next edge: `out_data<=src_data[w]`, `out_src<=w`, `out_valid<=1`, `last<=w`, go to SEND.
  - If no source is valid, stay in IDLE with all `src_ready` at 0.
- **SEND**
  - Hold `out_valid`, `out_data` and `out_src` stable. All `src_ready` are 0.
  - On `out_valid&&out_ready`: `out_valid<=0`.
  - If HOLD_CYCLES>0, load `cnt<=HOLD_CYCLES-1` and go to HOLD. Otherwise go to IDLE.
- **HOLD**
  - All `src_ready` are 0. `out_data`/`out_src` retain the last word.
  - `cnt` decrements each cycle. When `cnt==0`, go to IDLE on the next edge.
- Counter width is `$clog2(HOLD_CYCLES+1)`, unsigned, and must not wrap (loaded only on SEND exit).
- `last` resets to NUM_SRC-1, so source 0 wins the first arbitration.
- `src_valid` deassertion while a source is not granted is legal. Sources are never stalled except by arbitration.
- `src_ready` is forced to 0 while `rst` is low.
- Reset mid-operation: any in-flight word is discarded and state, `last` and `cnt` are reinitialised. No partial handshake completes.

## Timing
- Reset values:
  - `out_valid=0`, `out_data=0`, `out_src=0`, `src_ready=0`, `busy=0`
  - `last=NUM_SRC-1`, `cnt=0`
- Source accept → `out_valid` high: 1 cycle.
- Sink handshake → HOLD entry: same edge. Earliest next `src_ready`: HOLD_CYCLES+1 cycles after the sink handshake.
- Peak throughput with HOLD_CYCLES=0 and `out_ready` tied high: 1 word per 2 cycles.
- `out_ready` low in SEND stalls indefinitely with no timeout and no data change.
- Simultaneous requests: exactly one grant per IDLE cycle. Each valid source is granted within NUM_SRC arbitrations.

## Configuration
- `DISPLAY_ARB_PRIO_EN` defined:
  - Source 0 has strict priority. Whenever `src_valid[0]` is high in IDLE it wins.
  - `last` is not updated by a source-0 grant.
  - Sources 1..NUM_SRC-1 round-robin among themselves.
- Undefined: pure round-robin over all sources as described above.

## Test plan
- Reset and single source: hold `rst` low with `src_valid=4'b0001`, then release, with `src_data[0]=32'hDEAD_BEEF`, HOLD_CYCLES=4.
  - Expected: `src_ready` 0 during reset; `src_ready[0]` high in the first IDLE cycle.
  - Expected: `out_valid`=1 with `32'hDEAD_BEEF` and `out_src=0` on the next cycle.
- Dwell: `out_ready=1` with source 0 continuously valid, HOLD_CYCLES=4.
  - Expected: `src_ready[0]` pulses every 6 cycles; `busy` low only on the grant cycles.
- Fairness: all four sources valid continuously, HOLD_CYCLES=0, `out_ready=1`.
  - Expected: `out_src` sequence 0,1,2,3,0,1…; each `src_ready` pulses once per 8 cycles.
- Sink backpressure: hold `out_ready=0` for 10 cycles in SEND.
  - Expected: `out_valid`, `out_data` and `out_src` are constant and all `src_ready` stay 0.
  - Expected: handshake occurs on the cycle `out_ready` rises.
- Reset mid-HOLD: assert `rst` low during HOLD.
  - Expected: `out_valid=0` and `busy=0` immediately.
  - Expected: after release, the next grant goes to source 0 even if the last grant was 2.
- Macro test, with `DISPLAY_ARB_PRIO_EN` defined: sources 0 and 2 continuously valid, HOLD_CYCLES=0.
  - Expected: every grant goes to source 0.
  - Expected: when `src_valid[0]` drops, grants alternate among the valid sources 1..3 only.

Source files
------------

// File: rtl/display_arbiter.sv
// display_arbiter
//   Round-robin arbiter and pacing controller sharing one Avalon-ST display
//   sink between NUM_SRC word producers. One word is accepted from the
//   winning source, presented to the sink, and then further grants are held
//   off for HOLD_CYCLES so the value stays visible on the HEX/LED outputs.
//
//   Optional feature macro: DISPLAY_ARB_PRIO_EN
//     defined   : source 0 has strict priority and does not move the
//                 round-robin pointer; sources 1..NUM_SRC-1 rotate among
//                 themselves.
//     undefined : pure round-robin over all sources.
//
// Ports
//   clk        system clock (50 MHz)
//   rst        asynchronous reset, active low
//   src_data   NUM_SRC packed words, source i at [i*DATA_W +: DATA_W]
//   src_valid  per-source valid
//   src_ready  per-source ready (ready latency 0), one-hot or zero
//   out_data   word presented to the display sink
//   out_src    index of the source that produced out_data
//   out_valid  valid to the display sink
//   out_ready  ready from the display sink
//   busy       high whenever the arbiter is not idle
module display_arbiter #(
  parameter int NUM_SRC     = 4,
  parameter int DATA_W      = 32,
  parameter int HOLD_CYCLES = 50_000_000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_SRC*DATA_W-1:0] src_data,
  input  logic [NUM_SRC-1:0]        src_valid,
  output logic [NUM_SRC-1:0]        src_ready,
  output logic [DATA_W-1:0]         out_data,
  output logic [2:0]                out_src,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      busy
);

`ifdef DISPLAY_ARB_PRIO_EN
  localparam bit PRIO_EN = 1'b1;
`else
  localparam bit PRIO_EN = 1'b0;
`endif

  // A zero-width counter is illegal, so keep at least one bit when dwell is off.
  localparam int CNT_W = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;

  typedef enum logic [1:0] {IDLE, SEND, HOLD} state_t;

  state_t             state;
  logic [2:0]         last;
  logic [CNT_W-1:0]   cnt;

  logic               gnt_found;
  logic [2:0]         gnt_idx;
  logic [DATA_W-1:0]  gnt_data;

  // Winner search: scan last+1, last+2, ... wrapping at NUM_SRC. With the
  // priority feature, source 0 is taken first and skipped by the scan.
  always_comb begin : arb
    int                 idx;
    logic [NUM_SRC-1:0] sv_rot;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    idx       = 0;
    sv_rot    = '0;
    if (PRIO_EN && src_valid[0]) begin
      gnt_found = 1'b1;
      gnt_idx   = '0;
    end
    for (int k = 1; k <= NUM_SRC; k++) begin
      idx = int'(last) + k;
      if (idx >= NUM_SRC) idx = idx - NUM_SRC;
      sv_rot = src_valid >> idx;
      if (!gnt_found && sv_rot[0] && !(PRIO_EN && idx == 0)) begin
        gnt_found = 1'b1;
        gnt_idx   = 3'(idx);
      end
    end
  end

  assign gnt_data = DATA_W'(src_data >> (int'(gnt_idx) * DATA_W));

  // Ready is only offered in IDLE and is suppressed while reset is asserted,
  // so no handshake can complete during reset.
  always_comb begin
    src_ready = '0;
    if (rst && state == IDLE && gnt_found)
      src_ready = NUM_SRC'(1) << gnt_idx;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      last      <= 3'(NUM_SRC - 1);
      cnt       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt_found) begin
            out_data  <= gnt_data;
            out_src   <= gnt_idx;
            out_valid <= 1'b1;
            busy      <= 1'b1;
            // A priority grant to source 0 leaves the rotation untouched.
            if (!(PRIO_EN && gnt_idx == 3'd0))
              last <= gnt_idx;
            state <= SEND;
          end
        end
        SEND: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (HOLD_CYCLES > 0) begin
              cnt   <= CNT_W'(HOLD_CYCLES - 1);
              state <= HOLD;
            end else begin
              busy  <= 1'b0;
              state <= IDLE;
            end
          end
        end
        HOLD: begin
          if (cnt == '0) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_display_arbiter.sv
// tb_display_arbiter
//   Two arbiter instances (dwell of 4 cycles and dwell disabled) driven by the
//   same stimulus. Each is compared every cycle against a transaction-level
//   reference: a word is either on display, or the dwell window has a number
//   of cycles left, or the arbiter is free and grants per the rotation rule.
module tb_display_arbiter;

`ifdef DISPLAY_ARB_PRIO_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  logic         clk;
  logic         rst;
  logic [127:0] src_data;
  logic [3:0]   src_valid;
  logic         out_ready;
  logic [31:0]  word [4];

  logic [3:0]   rdy4, rdy0;
  logic [31:0]  od4, od0;
  logic [2:0]   os4, os0;
  logic         ov4, ov0, bz4, bz0;

  int n_vec = 0;
  int n_bad = 0;

  // reference state, index 0 = dwell 4, index 1 = dwell 0
  bit          m_ov   [2];
  logic [31:0] m_data [2];
  int          m_src  [2];
  int          m_last [2];
  int          m_wait [2];

  display_arbiter #(.NUM_SRC(4), .DATA_W(32), .HOLD_CYCLES(4)) u_hold4 (
    .clk(clk), .rst(rst), .src_data(src_data), .src_valid(src_valid),
    .src_ready(rdy4), .out_data(od4), .out_src(os4), .out_valid(ov4),
    .out_ready(out_ready), .busy(bz4));

  display_arbiter #(.NUM_SRC(4), .DATA_W(32), .HOLD_CYCLES(0)) u_hold0 (
    .clk(clk), .rst(rst), .src_data(src_data), .src_valid(src_valid),
    .src_ready(rdy0), .out_data(od0), .out_src(os0), .out_valid(ov0),
    .out_ready(out_ready), .busy(bz0));

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Rotation rule: first valid source after the last winner, wrapping.
  function automatic int pick(input logic [3:0] v, input int last);
    if (PRIO && v[0]) return 0;
    for (int k = 1; k <= 4; k++) begin
      int i;
      i = (last + k) % 4;
      if (PRIO && i == 0) continue;
      if (((v >> i) & 4'd1) != 4'd0) return i;
    end
    return -1;
  endfunction

  task automatic model_reset(input int m);
    m_ov[m]   = 1'b0;
    m_data[m] = 32'h0;
    m_src[m]  = 0;
    m_last[m] = 3;
    m_wait[m] = 0;
  endtask

  task automatic compare(input int m, input logic [3:0] rdy, input logic ov,
                         input logic [31:0] od, input logic [2:0] os, input logic bz);
    string    p;
    int       hold;
    int       w;
    logic [3:0] e_rdy;
    logic       e_bz;
    p    = (m == 0) ? "h4" : "h0";
    hold = (m == 0) ? 4 : 0;
    w    = -1;
    if (!rst) begin
      model_reset(m);
      check({p, ".rst_ready"}, 32'(rdy), 32'h0);
      check({p, ".rst_valid"}, 32'(ov), 32'h0);
      check({p, ".rst_busy"},  32'(bz), 32'h0);
      check({p, ".rst_data"},  od, 32'h0);
      check({p, ".rst_src"},   32'(os), 32'h0);
      return;
    end
    e_rdy = 4'b0;
    if (m_ov[m] || m_wait[m] > 0) begin
      e_bz = 1'b1;
    end else begin
      e_bz = 1'b0;
      w = pick(src_valid, m_last[m]);
      if (w >= 0) e_rdy = 4'b0001 << w;
    end
    check({p, ".ready"}, 32'(rdy), 32'(e_rdy));
    check({p, ".valid"}, 32'(ov), 32'(m_ov[m]));
    check({p, ".busy"},  32'(bz), 32'(e_bz));
    check({p, ".data"},  od, m_data[m]);
    check({p, ".src"},   32'(os), 32'(m_src[m]));
    // advance to the state seen after the coming clock edge
    if (m_ov[m]) begin
      if (out_ready) begin
        m_ov[m]   = 1'b0;
        m_wait[m] = hold;
      end
    end else if (m_wait[m] > 0) begin
      m_wait[m]--;
    end else if (w >= 0) begin
      m_ov[m]   = 1'b1;
      m_data[m] = word[w];
      m_src[m]  = w;
      if (!(PRIO && w == 0)) m_last[m] = w;
    end
  endtask

  task automatic tick(input logic r, input logic [3:0] v, input logic ord, input bit rnd);
    @(posedge clk);
    #1;
    if (rnd) for (int i = 0; i < 4; i++) word[i] = $urandom;
    src_data  = {word[3], word[2], word[1], word[0]};
    rst       = r;
    src_valid = v;
    out_ready = ord;
    @(negedge clk);
    compare(0, rdy4, ov4, od4, os4, bz4);
    compare(1, rdy0, ov0, od0, os0, bz0);
  endtask

  initial begin
    word[0] = 32'hDEAD_BEEF;
    word[1] = 32'h1111_0001;
    word[2] = 32'h2222_0002;
    word[3] = 32'h3333_0003;
    src_data  = {word[3], word[2], word[1], word[0]};
    src_valid = 4'b0001;
    out_ready = 1'b1;
    rst = 1'b1;
    model_reset(0);
    model_reset(1);
    #2 rst = 1'b0;

    // reset held with source 0 requesting, then single-source dwell
    repeat (3)  tick(1'b0, 4'b0001, 1'b1, 1'b0);
    repeat (20) tick(1'b1, 4'b0001, 1'b1, 1'b0);

    // fairness with everyone requesting
    repeat (40) tick(1'b1, 4'b1111, 1'b1, 1'b1);

    // sink backpressure for a long stretch, then release
    repeat (12) tick(1'b1, 4'b1111, 1'b0, 1'b1);
    repeat (10) tick(1'b1, 4'b1111, 1'b1, 1'b1);

    // reset while the dwell instance is in its hold window after a grant to 2
    repeat (2)  tick(1'b0, 4'b0100, 1'b1, 1'b0);
    tick(1'b1, 4'b0100, 1'b1, 1'b0);
    tick(1'b1, 4'b0000, 1'b1, 1'b0);
    tick(1'b1, 4'b0000, 1'b1, 1'b0);
    tick(1'b0, 4'b1111, 1'b1, 1'b0);
    repeat (10) tick(1'b1, 4'b1111, 1'b1, 1'b1);

    // sources 0 and 2 together, then source 0 withdraws
    repeat (20) tick(1'b1, 4'b0101, 1'b1, 1'b1);
    repeat (20) tick(1'b1, 4'b1110, 1'b1, 1'b1);

    // randomized traffic, backpressure and occasional resets
    for (int c = 0; c < 1500; c++) begin
      logic [3:0] v;
      v = 4'($urandom);
      if ($urandom_range(0, 3) == 0) v = 4'b0;
      tick(($urandom_range(0, 99) != 0), v, ($urandom_range(0, 3) != 0), 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
